instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of word_count.
REQ-002 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have port in_valid  in  1  an instruction's fields are presented.
REQ-005 SHALL have port in_ready  out  1  encoder can accept an instruction.
REQ-006 SHALL have port in_op  in  6  opcode (NOP=0x00 .. PUSH=0x15).
REQ-007 SHALL have port in_ad  in  3  destination addressing mode.
REQ-008 SHALL have port in_as  in  3  source addressing mode.
REQ-009 SHALL have port in_dst  in  4  destination register.
REQ-010 SHALL have port in_src  in  16  source operand, or jump target for jump opcodes.
REQ-011 SHALL have port out_valid  out  1  out_word is valid.
REQ-012 SHALL have port out_ready  in  1  downstream consumer accepts out_word.
REQ-013 SHALL have port out_word  out  16  instruction word.
REQ-014 SHALL have port out_last  out  1  out_word is the final word of its instruction.
REQ-015 SHALL have port err_illegal  out  1  one-cycle pulse when an illegal opcode is dropped.
REQ-016 SHALL have port word_count  out  CNT_W  count of words accepted downstream.

Function
REQ-017 SHALL implement FSM states IDLE, WORD0 and WORD1; in_ready SHALL be 1 only in IDLE.
REQ-018 SHALL, on in_valid&&in_ready, register all fields and enter WORD0 next cycle; out_valid SHALL be 1 exactly one cycle after acceptance.
REQ-019 SHALL classify long opcodes as JZ 0x09, JNZ 0x0A, JSR 0x0B, LD 0x0C, ST 0x0D, ADD 0x0E, SUB 0x0F, AND 0x10, OR 0x11 and XOR 0x13; all other opcodes are short.
REQ-020 SHALL form WORD0 as {op[5:0], ad[2:0], as[2:0], dst[3:0]} (bits 15:10, 9:7, 6:4, 3:0).
REQ-021 SHALL form the as and dst fields of WORD0 as 0 for JZ, JNZ and JSR.
REQ-022 SHALL emit in_src as WORD1 for long opcodes only.
REQ-023 SHALL set out_last=1 on WORD0 of short opcodes and on WORD1, and out_last=0 on WORD0 of long opcodes.
REQ-024 SHALL, on out_valid&&out_ready in WORD0, go to WORD1 if long, else IDLE; on the WORD1 handshake it SHALL go to IDLE.
REQ-025 SHALL hold out_word and out_last stable while out_valid=1 and out_ready=0; out_valid SHALL NOT drop before the handshake.
REQ-026 SHALL drive out_word=0 and out_last=0 while out_valid=0.
REQ-027 SHALL increment word_count by 1 per output handshake and wrap from all-ones to 0.
REQ-028 SHALL define an illegal opcode as any value above 0x15.
REQ-029 SHALL sample in_* fields only at acceptance; changes to in_* fields during WORD0 or WORD1 have no effect.

Reset
REQ-030 SHALL, while reset=1, force state to IDLE, out_valid=0, out_word=0, out_last=0, err_illegal=0 and word_count=0, with in_ready=1.
REQ-031 SHALL discard any partially emitted instruction when reset is asserted mid-operation; no residual word is emitted after release.

Configuration
REQ-032 SHALL, with INSTR_ENC_ILLEGAL_CHK_EN defined, accept an illegal opcode, emit no words, pulse err_illegal for the cycle after acceptance and stay in IDLE.
REQ-033 SHALL, without INSTR_ENC_ILLEGAL_CHK_EN, tie err_illegal to 0 and encode an illegal opcode as a short instruction.

Structure
REQ-034 SHALL take opcode constants, addressing-mode constants (REGISTER=0, IMMEDIATE=1, ABSOLUTE=2), the FSM state typedef and an is_long function from shared package cpu_isa_pkg, which the decoder also uses.
REQ-035 SHALL implement word formatting (REQ-020/021/022) in combinational sub-module instr_word_fmt; the FSM, counter and handshake stay in instr_encoder.

Verification
REQ-036 SHALL verify: INC op=0x01, ad=0, as=0, dst=5, out_ready=1 -> one word 0x0405 with out_last=1, word_count=1.
REQ-037 SHALL verify: ADD op=0x0E, ad=0, as=1, dst=3, src=0x1234 -> 0x3813 (last=0), then 0x1234 (last=1); word_count +2.
REQ-038 SHALL verify: JZ op=0x09, dst=7, src=0x00A0 -> 0x2400 then 0x00A0.
REQ-039 SHALL verify: ADD as in REQ-037 with out_ready=0 for 3 cycles -> out_word holds 0x3813, out_valid stays 1, in_ready stays 0.
REQ-040 SHALL verify: op=0x3F, all other fields 0 -> with macro, err_illegal=1 for one cycle, no out_valid, word_count unchanged; without macro, word 0xFC00 with last=1.
REQ-041 SHALL verify: reset asserted after the WORD0 handshake of ADD -> out_valid=0 immediately, word_count=0, in_ready=1, and no 0x1234 after release.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcodes, addressing modes,
// encoder FSM states and opcode classification helpers.
package cpu_isa_pkg;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_INC  = 6'h01;
    localparam logic [5:0] OP_JZ   = 6'h09;
    localparam logic [5:0] OP_JNZ  = 6'h0A;
    localparam logic [5:0] OP_JSR  = 6'h0B;
    localparam logic [5:0] OP_LD   = 6'h0C;
    localparam logic [5:0] OP_ST   = 6'h0D;
    localparam logic [5:0] OP_ADD  = 6'h0E;
    localparam logic [5:0] OP_SUB  = 6'h0F;
    localparam logic [5:0] OP_AND  = 6'h10;
    localparam logic [5:0] OP_OR   = 6'h11;
    localparam logic [5:0] OP_XOR  = 6'h13;
    localparam logic [5:0] OP_PUSH = 6'h15;

    localparam logic [2:0] AM_REGISTER  = 3'd0;
    localparam logic [2:0] AM_IMMEDIATE = 3'd1;
    localparam logic [2:0] AM_ABSOLUTE  = 3'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WORD0 = 2'd1,
        WORD1 = 2'd2
    } enc_state_t;

    // Opcodes that carry a second (operand/target) word.
    function automatic logic is_long(input logic [5:0] op);
        logic r;
        r = 1'b0;
        unique case (1'b1)
            op == OP_JZ,  op == OP_JNZ, op == OP_JSR,
            op == OP_LD,  op == OP_ST,  op == OP_ADD,
            op == OP_SUB, op == OP_AND, op == OP_OR,
            op == OP_XOR: r = 1'b1;
            default:      r = 1'b0;
        endcase
        return r;
    endfunction

    // Jumps carry no source mode or destination register.
    function automatic logic is_jump(input logic [5:0] op);
        return (op == OP_JZ) || (op == OP_JNZ) || (op == OP_JSR);
    endfunction

    function automatic logic is_illegal(input logic [5:0] op);
        return op > OP_PUSH;
    endfunction

endpackage

// File: rtl/instr_word_fmt.sv
// Combinational formatter: builds the opcode word and the
// trailing operand word from registered instruction fields.
module instr_word_fmt
    import cpu_isa_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [2:0]  ad,
    input  logic [2:0]  as,
    input  logic [3:0]  dst,
    input  logic [15:0] src,
    output logic [15:0] word0,
    output logic [15:0] word1,
    output logic        long_op
);

    logic       jump;
    logic [2:0] as_f;
    logic [3:0] dst_f;

    // Jump opcodes zero the source-mode and register fields.
    always_comb begin
        jump    = is_jump(op);
        long_op = is_long(op);
        as_f    = jump ? 3'd0 : as;
        dst_f   = jump ? 4'd0 : dst;
        word0   = {op, ad, as_f, dst_f};
        word1   = long_op ? src : 16'd0;
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded fields, emits 1-2 words.
// Option: INSTR_ENC_ILLEGAL_CHK_EN drops opcodes above PUSH.
module instr_encoder
    import cpu_isa_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_op,
    input  logic [2:0]       in_ad,
    input  logic [2:0]       in_as,
    input  logic [3:0]       in_dst,
    input  logic [15:0]      in_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_word,
    output logic             out_last,
    output logic             err_illegal,
    output logic [CNT_W-1:0] word_count
);

    enc_state_t  state_q;
    enc_state_t  state_d;
    logic [5:0]  op_q;
    logic [2:0]  ad_q;
    logic [2:0]  as_q;
    logic [3:0]  dst_q;
    logic [15:0] src_q;
    logic [15:0] word0;
    logic [15:0] word1;
    logic        long_op;
    logic        accept;
    logic        out_hs;
    logic        drop;

    assign accept = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

`ifdef INSTR_ENC_ILLEGAL_CHK_EN
    assign drop = is_illegal(in_op);
`else
    assign drop = 1'b0;
`endif

    instr_word_fmt u_fmt (
        .op      (op_q),
        .ad      (ad_q),
        .as      (as_q),
        .dst     (dst_q),
        .src     (src_q),
        .word0   (word0),
        .word1   (word1),
        .long_op (long_op)
    );

    // Capture instruction fields only at acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= '0;
            ad_q  <= '0;
            as_q  <= '0;
            dst_q <= '0;
            src_q <= '0;
        end else if (accept) begin
            op_q  <= in_op;
            ad_q  <= in_ad;
            as_q  <= in_as;
            dst_q <= in_dst;
            src_q <= in_src;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_word  = 16'd0;
        out_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (accept && !drop) state_d = WORD0;
            end
            WORD0: begin
                out_valid = 1'b1;
                out_word  = word0;
                out_last  = !long_op;
                if (out_hs) state_d = long_op ? WORD1 : IDLE;
            end
            WORD1: begin
                out_valid = 1'b1;
                out_word  = word1;
                out_last  = 1'b1;
                if (out_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Downstream word counter, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       word_count <= '0;
        else if (out_hs) word_count <= word_count + CNT_W'(1);
    end

`ifdef INSTR_ENC_ILLEGAL_CHK_EN
    // One-cycle pulse after a dropped illegal opcode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_illegal <= 1'b0;
        else       err_illegal <= accept && drop;
    end
`else
    assign err_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder.
// Expected words are hand-computed from the field layout.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [2:0]  in_ad;
    logic [2:0]  in_as;
    logic [3:0]  in_dst;
    logic [15:0] in_src;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic        out_last;
    logic        err_illegal;
    logic [15:0] word_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_encoder #(.CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_ad       (in_ad),
        .in_as       (in_as),
        .in_dst      (in_dst),
        .in_src      (in_src),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_last    (out_last),
        .err_illegal (err_illegal),
        .word_count  (word_count)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one edge; returns #1 after it.
    task automatic send(input logic [5:0] op, input logic [2:0] ad,
                        input logic [2:0] as, input logic [3:0] dst,
                        input logic [15:0] src);
        @(negedge clk);
        in_op    = op;
        in_ad    = ad;
        in_as    = as;
        in_dst   = dst;
        in_src   = src;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_ad     = '0;
        in_as     = '0;
        in_dst    = '0;
        in_src    = '0;
        out_ready = 1'b1;
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_word",  32'(out_word), 32'd0);
        check("rst_last",  32'(out_last), 32'd0);
        check("rst_err",   32'(err_illegal), 32'd0);
        check("rst_cnt",   32'(word_count), 32'd0);
        check("rst_rdy",   32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // INC r5: single word
        send(6'h01, 3'd0, 3'd0, 4'd5, 16'h0000);
        check("inc_valid", 32'(out_valid), 32'd1);
        check("inc_word",  32'(out_word), 32'h0405);
        check("inc_last",  32'(out_last), 32'd1);
        check("inc_rdy",   32'(in_ready), 32'd0);
        step();
        check("inc_done",  32'(out_valid), 32'd0);
        check("inc_cnt",   32'(word_count), 32'd1);
        check("inc_rdy2",  32'(in_ready), 32'd1);

        // ADD: two words
        send(6'h0E, 3'd0, 3'd1, 4'd3, 16'h1234);
        check("add_w0",   32'(out_word), 32'h3813);
        check("add_l0",   32'(out_last), 32'd0);
        step();
        check("add_v1",   32'(out_valid), 32'd1);
        check("add_w1",   32'(out_word), 32'h1234);
        check("add_l1",   32'(out_last), 32'd1);
        step();
        check("add_done", 32'(out_valid), 32'd0);
        check("add_cnt",  32'(word_count), 32'd3);

        // JZ: as/dst fields zeroed
        send(6'h09, 3'd0, 3'd0, 4'd7, 16'h00A0);
        check("jz_w0",  32'(out_word), 32'h2400);
        check("jz_l0",  32'(out_last), 32'd0);
        step();
        check("jz_w1",  32'(out_word), 32'h00A0);
        check("jz_l1",  32'(out_last), 32'd1);
        step();
        check("jz_cnt", 32'(word_count), 32'd5);

        // ADD with backpressure; inputs changed while busy
        out_ready = 1'b0;
        send(6'h0E, 3'd0, 3'd1, 4'd3, 16'h1234);
        in_src = 16'hFFFF;
        in_op  = 6'h01;
        for (int i = 0; i < 3; i++) begin
            check("stl_word",  32'(out_word), 32'h3813);
            check("stl_valid", 32'(out_valid), 32'd1);
            check("stl_rdy",   32'(in_ready), 32'd0);
            check("stl_cnt",   32'(word_count), 32'd5);
            step();
        end
        out_ready = 1'b1;
        step();
        check("stl_w1",  32'(out_word), 32'h1234);
        check("stl_l1",  32'(out_last), 32'd1);
        step();
        check("stl_cnt2", 32'(word_count), 32'd7);

        // Illegal opcode 0x3F
        send(6'h3F, 3'd0, 3'd0, 4'd0, 16'h0000);
`ifdef INSTR_ENC_ILLEGAL_CHK_EN
        check("ill_err",   32'(err_illegal), 32'd1);
        check("ill_valid", 32'(out_valid), 32'd0);
        check("ill_rdy",   32'(in_ready), 32'd1);
        step();
        check("ill_err2",  32'(err_illegal), 32'd0);
        check("ill_vld2",  32'(out_valid), 32'd0);
        check("ill_cnt",   32'(word_count), 32'd7);
`else
        check("ill_word",  32'(out_word), 32'hFC00);
        check("ill_last",  32'(out_last), 32'd1);
        check("ill_err",   32'(err_illegal), 32'd0);
        step();
        check("ill_done",  32'(out_valid), 32'd0);
        check("ill_cnt",   32'(word_count), 32'd8);
`endif

        // Reset after WORD0 handshake of ADD
        send(6'h0E, 3'd0, 3'd1, 4'd3, 16'h1234);
        check("mr_w0", 32'(out_word), 32'h3813);
        step();
        check("mr_w1", 32'(out_word), 32'h1234);
        reset = 1'b1;
        #1;
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_word",  32'(out_word), 32'd0);
        check("mr_cnt",   32'(word_count), 32'd0);
        check("mr_rdy",   32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mr_quiet", 32'(out_valid), 32'd0);
            check("mr_word2", 32'(out_word), 32'd0);
        end
        check("mr_cnt2", 32'(word_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
